// File: rtl/mux2_rr_if.sv
// Stream bundle for mux2_rr: two producer channels in, one tagged channel out.
// The slave side is the multiplexer; the master side is its producers/consumer.
interface mux2_rr_if #(
    parameter int W = 8
);
    logic [W-1:0] d0;
    logic         v0;
    logic         r0;
    logic [W-1:0] d1;
    logic         v1;
    logic         r1;
    logic [W-1:0] z0;
    logic         zv;
    logic         zr;
    logic         s0;

    modport master (
        output d0, v0, d1, v1, zr,
        input  r0, r1, z0, zv, s0
    );

    modport slave (
        input  d0, v0, d1, v1, zr,
        output r0, r1, z0, zv, s0
    );
endinterface

// File: rtl/mux2_rr.sv
// 2:1 round-robin stream merge into one registered output word with source tag.
// Optional per-channel grant counters c0/c1 via MUX2_RR_GRANT_CNT_EN.
module mux2_rr #(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       rst,
    mux2_rr_if.slave   bus
`ifdef MUX2_RR_GRANT_CNT_EN
    ,
    output logic [7:0] c0,
    output logic [7:0] c1
`endif
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] z_q, z_d;
    logic         s_q, s_d;
    logic         last_q, last_d;
    logic         ld;
    logic         g0;
    logic         g1;

    assign ld = (state_q == EMPTY) | bus.zr;
    // On a tie the channel not granted last time wins.
    assign g0 = bus.v0 & (~bus.v1 | last_q);
    assign g1 = bus.v1 & (~bus.v0 | ~last_q);

    assign bus.r0 = ld & g0;
    assign bus.r1 = ld & g1;
    assign bus.z0 = z_q;
    assign bus.zv = (state_q == FULL);
    assign bus.s0 = s_q;

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        s_d     = s_q;
        last_d  = last_q;
        if (bus.r0 | bus.r1) begin
            state_d = FULL;
            z_d     = bus.r1 ? bus.d1 : bus.d0;
            s_d     = bus.r1;
            last_d  = bus.r1;
        end else if (bus.zr) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            z_q     <= '0;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            s_q     <= s_d;
            last_q  <= last_d;
        end
    end

`ifdef MUX2_RR_GRANT_CNT_EN
    logic [7:0] c0_q, c0_d;
    logic [7:0] c1_q, c1_d;

    always_comb begin
        c0_d = c0_q + {7'd0, bus.r0};
        c1_d = c1_q + {7'd0, bus.r1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c0_q <= 8'd0;
            c1_q <= 8'd0;
        end else begin
            c0_q <= c0_d;
            c1_q <= c1_d;
        end
    end

    assign c0 = c0_q;
    assign c1 = c1_q;
`endif
endmodule

// File: doc/mux2_rr.md
Name: mux2_rr

Overview:
- Sequential 2:1 stream multiplexer with a round-robin arbiter. It is the merging counterpart of the 1:2 demultiplexer.
- Two valid/ready input channels (d0, d1) are merged into one registered output channel.
- Each output word carries a select tag (s0) so a downstream dmux2 can route it back to the matching output (z0/z1).
- Sits between two producers and a shared serial/bus consumer.

Parameters:
- W, 8, data width of each input channel and of the output.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- d0  input  W  channel 0 data
- v0  input  1  channel 0 valid
- r0  output  1  channel 0 ready (combinational)
- d1  input  W  channel 1 data
- v1  input  1  channel 1 valid
- r1  output  1  channel 1 ready (combinational)
- z0  output  W  merged output data (registered)
- zv  output  1  output valid (registered)
- zr  input  1  output ready from consumer
- s0  output  1  source tag of z0: 0 = channel 0, 1 = channel 1 (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: zv=0, z0=0, s0=0, internal last-grant register last=1, so channel 0 wins the first tie. r0/r1 follow from zv=0 and the inputs.
- Handshake: a transfer occurs on a channel when valid and ready are both 1 at the rising edge.
  - Producers must hold data and valid stable until accepted.
  - zv, once asserted, stays asserted with z0/s0 stable until zr=1.
- States (single output register):
  - EMPTY (zv=0).
  - FULL (zv=1).
- Load enable: ld = ~zv | zr.
  - An accepted output and a new load may occur in the same cycle, giving full throughput of one word per cycle.
- Arbitration (combinational, evaluated only when ld=1):
  - only v0=1 → grant 0
  - only v1=1 → grant 1
  - both → grant to ~last
  - neither → no grant
- r0 = ld & grant0; r1 = ld & grant1. Never both 1 in the same cycle.
- On a granted transfer:
  - z0 ← d[grant], s0 ← grant, zv ← 1, last ← grant.
  - Latency: input accepted at edge N appears on z0 with zv=1 immediately after edge N (one register stage).
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→EMPTY when zr=1 and no grant.
  - FULL→FULL when zr=0 (hold), or when zr=1 with a grant (replace).
  - EMPTY→EMPTY with no valid inputs.
- Boundary conditions:
  - zr=0 while FULL: r0=r1=0, output held, last unchanged.
  - Both inputs valid continuously with zr=1: strict alternation 0,1,0,1… No channel waits more than one grant.
  - Single channel valid continuously: that channel is granted every cycle. last tracks it, so the other channel wins the next tie.
  - zr asserted while EMPTY: ignored.
  - Reset mid-operation: the pending output word is discarded, zv=0 on the next cycle, last=1.
  - An input word not yet accepted is not consumed; the producer keeps it.

Optional Feature:
- Macro: MUX2_RR_GRANT_CNT_EN.
- Defined:
  - Adds outputs c0 and c1 (each 8 bits, registered, reset to 0).
  - c0/c1 increment on each accepted transfer on channel 0/1 respectively.
  - Counters wrap 255→0.
  - Both counters are unaffected by zr and are cleared only by rst.
- Not defined:
  - Ports c0/c1 and the counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then v0=v1=0 → zv=0, z0=0, s0=0, r0=r1=0 held.
- Single channel: v1=1, d1=8'hA5, zr=1 for 1 cycle → r1=1 that cycle; next cycle zv=1, z0=8'hA5, s0=1.
- Contention after reset: v0=v1=1, d0=8'h11, d1=8'h22, zr=1 for 4 cycles → output sequence (11,s0=0),(22,1),(11,0),(22,1), one per cycle.
- Backpressure: output FULL with 8'h33, zr=0 for 3 cycles with v0=1 → z0=8'h33 stable, r0=0. After zr=1, next word loads in the same cycle, with no gap and no duplication.
- Reset mid-stream: zv=1, zr=0, assert rst for 1 cycle → zv=0 next cycle. With v0=v1=1 afterwards, channel 0 is granted first.
- With MUX2_RR_GRANT_CNT_EN: 300 accepted channel-0 transfers → c0=44 (300 mod 256), c1=0.
